// File: rtl/irq_request_latch_if.sv
// irq_request_latch_if
// Bundles the request lines, the external priority-encoder loop and the
// consumer handshake of irq_request_latch.
//   irq_in    : raw request lines (synchronous to clk)
//   mask      : per-line service enable
//   pend      : pending & mask, feeds the external priority encoder
//   idx_in    : encoder result for the current pend value
//   ack       : consumer acknowledge of the presented request
//   irq_req   : registered request-valid flag
//   irq_idx   : registered index of the presented request
//   drop_cnt  : saturating count of requests lost to an already-pending bit
//   fsm_state : debug view of the presentation state machine
// Handshake: irq_req is a valid that stays high, with irq_idx stable, until
// a cycle in which ack=1 is sampled; that cycle completes the transfer.
// ack is ignored whenever irq_req is low.
// The master modport is the environment (sources + encoder + consumer); the
// slave modport is the latch itself.
interface irq_request_latch_if;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic [7:0] pend;
  logic [2:0] idx_in;
  logic       ack;
  logic       irq_req;
  logic [2:0] irq_idx;
  logic [7:0] drop_cnt;
  logic [1:0] fsm_state;

  modport master (
    output irq_in, mask, idx_in, ack,
    input  pend, irq_req, irq_idx, drop_cnt, fsm_state
  );

  modport slave (
    input  irq_in, mask, idx_in, ack,
    output pend, irq_req, irq_idx, drop_cnt, fsm_state
  );
endinterface

// File: rtl/irq_request_latch.sv
// irq_request_latch
// Captures request lines into a pending register (rising-edge or level mode),
// presents one masked pending request at a time using the index returned by
// an external priority encoder, and counts requests lost because their line
// was already pending.
// Ports:
//   clk : single clock, all state updates on its rising edge
//   rst : synchronous active-high reset
//   bus : irq_request_latch_if.slave (see the interface for signal list)
// Parameters:
//   WIDTH : number of request lines (only 8 is supported)
//   EDGE  : 1 = rising-edge capture, 0 = level capture
module irq_request_latch #(
  parameter int WIDTH = 8,
  parameter bit EDGE  = 1'b1
) (
  input logic               clk,
  input logic               rst,
  irq_request_latch_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] pend_reg;
  logic [WIDTH-1:0] pend_w;
  logic [WIDTH-1:0] capture;
  logic [WIDTH-1:0] clr_vec;
  logic [WIDTH-1:0] drop_vec;
  logic [3:0]       drop_num;
  logic [8:0]       drop_sum;
  logic             ack_clear;
  logic             irq_req_r;
  logic [2:0]       irq_idx_r;
  logic [7:0]       drop_cnt_r;

  always_comb begin
    capture   = EDGE ? (bus.irq_in & ~prev) : bus.irq_in;
    pend_w    = pend_reg & bus.mask;
    ack_clear = (state == REQ) && bus.ack;
    clr_vec   = ack_clear ? ({{(WIDTH-1){1'b0}}, 1'b1} << irq_idx_r) : '0;
    // The acked line is excluded: a new edge on it re-arms the bit rather
    // than being lost, so it is not a drop.
    drop_vec  = EDGE ? (capture & pend_reg & ~clr_vec) : '0;
    drop_num  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      drop_num = drop_num + {3'b000, drop_vec[i]};
    end
    drop_sum  = {1'b0, drop_cnt_r} + {5'b00000, drop_num};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev       <= '0;
      pend_reg   <= '0;
      irq_req_r  <= 1'b0;
      irq_idx_r  <= 3'd0;
      drop_cnt_r <= 8'd0;
      state      <= IDLE;
    end else begin
      prev       <= bus.irq_in;
      // Capture is applied after the clear so it wins on a collision.
      pend_reg   <= (pend_reg & ~clr_vec) | capture;
      drop_cnt_r <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      case (state)
        IDLE: begin
          // idx_in is only meaningful when pend is non-zero.
          if (|pend_w) begin
            irq_idx_r <= bus.idx_in;
            irq_req_r <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.ack) begin
            irq_req_r <= 1'b0;
            state     <= GAP;
          end
        end
        GAP: begin
          // One dead cycle lets the encoder settle on the cleared pend.
          state <= IDLE;
        end
        default: begin
          irq_req_r <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.pend      = pend_w;
  assign bus.irq_req   = irq_req_r;
  assign bus.irq_idx   = irq_idx_r;
  assign bus.drop_cnt  = drop_cnt_r;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_irq_request_latch.sv
// tb_irq_request_latch
// Self-checking bench for irq_request_latch. An edge-mode instance is
// checked against directed scenarios and a cycle-level reference model;
// a level-mode instance shares the inputs and is checked for capture and a
// constant-zero drop count. The external priority encoder is modelled as
// highest-set-bit with 0 for an all-zero input.
module tb_irq_request_latch;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  irq_request_latch_if bus ();
  irq_request_latch_if lvl ();

  irq_request_latch #(.WIDTH(8), .EDGE(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  irq_request_latch #(.WIDTH(8), .EDGE(1'b0)) dut_lvl (
    .clk (clk),
    .rst (rst),
    .bus (lvl)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [2:0] hi_bit(input logic [7:0] v);
    hi_bit = 3'd0;
    for (int i = 0; i < 8; i++) if (v[i]) hi_bit = i[2:0];
  endfunction

  // External encoders and shared inputs for the level-mode instance.
  assign bus.idx_in = hi_bit(bus.pend);
  assign lvl.idx_in = hi_bit(lvl.pend);
  assign lvl.irq_in = bus.irq_in;
  assign lvl.mask   = bus.mask;
  assign lvl.ack    = bus.ack;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model (edge mode) ----------------
  // Tracks pending lines as a set, plus "is a request shown", its index and
  // a cooldown of blank cycles after each accepted ack.
  logic [7:0] m_pend;
  logic [7:0] m_prev;
  logic       m_req;
  logic [2:0] m_idx;
  int         m_drop;
  int         m_cool;

  always @(posedge clk) begin
    logic [7:0] nxt;
    logic       rise;
    logic       cleared;
    if (rst) begin
      m_pend = '0; m_prev = '0; m_req = 1'b0; m_idx = 3'd0;
      m_drop = 0;  m_cool = 0;
    end else begin
      nxt = m_pend;
      for (int i = 0; i < 8; i++) begin
        rise    = bus.irq_in[i] && !m_prev[i];
        cleared = m_req && bus.ack && (m_idx == i);
        if (rise && m_pend[i] && !cleared && m_drop < 255) m_drop++;
        if (rise) nxt[i] = 1'b1;
        else if (cleared) nxt[i] = 1'b0;
      end
      if (m_req) begin
        if (bus.ack) begin m_req = 1'b0; m_cool = 1; end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if ((m_pend & bus.mask) != 8'h00) begin
        m_req = 1'b1;
        m_idx = hi_bit(m_pend & bus.mask);
      end
      m_pend = nxt;
      m_prev = bus.irq_in;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.irq_in = 8'h00; bus.mask = 8'hFF; bus.ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; bus.irq_in = 8'hFF; bus.mask = 8'hFF; bus.ack = 1'b1;
    tick(); tick();
    checks++; if (bus.pend !== 8'h00) begin errors++; $display("FAIL reset_pend got %h exp 00", bus.pend); end
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.irq_req); end
    checks++; if (bus.irq_idx !== 3'd0) begin errors++; $display("FAIL reset_idx got %0d exp 0", bus.irq_idx); end
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", bus.drop_cnt); end
    checks++; if (bus.fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", bus.fsm_state); end
    rst = 1'b0; bus.irq_in = 8'h00; bus.ack = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.irq_in = 8'h04; tick(); bus.irq_in = 8'h00;
    checks++; if (bus.pend !== 8'h04) begin errors++; $display("FAIL single_pend got %h exp 04", bus.pend); end
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL single_req_early got %b exp 0", bus.irq_req); end
    tick();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_idx !== 3'd2) begin errors++; $display("FAIL single_req got %b/%0d exp 1/2", bus.irq_req, bus.irq_idx); end
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    checks++; if (bus.pend !== 8'h00 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL single_ack got %h/%b exp 00/0", bus.pend, bus.irq_req); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.irq_in = 8'h82; tick(); bus.irq_in = 8'h00;
    checks++; if (bus.pend !== 8'h82) begin errors++; $display("FAIL simul_pend got %h exp 82", bus.pend); end
    tick();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_idx !== 3'd7) begin errors++; $display("FAIL simul_first got %b/%0d exp 1/7", bus.irq_req, bus.irq_idx); end
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    checks++; if (bus.pend !== 8'h02 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL simul_gap got %h/%b exp 02/0", bus.pend, bus.irq_req); end
    tick();
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL simul_idle got %b exp 0", bus.irq_req); end
    tick();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_idx !== 3'd1) begin errors++; $display("FAIL simul_second got %b/%0d exp 1/1", bus.irq_req, bus.irq_idx); end
    bus.ack = 1'b1; tick(); bus.ack = 1'b0;
    checks++; if (bus.pend !== 8'h00 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL simul_done got %h/%b exp 00/0", bus.pend, bus.irq_req); end
  endtask

  task automatic test_mask();
    bit seen = 1'b0;
    do_reset();
    bus.mask = 8'h7F;
    bus.irq_in = 8'h80; tick(); bus.irq_in = 8'h00;
    checks++; if (bus.pend !== 8'h00) begin errors++; $display("FAIL mask_pend got %h exp 00", bus.pend); end
    tick(); tick();
    checks++; if (bus.irq_req !== 1'b0) begin errors++; $display("FAIL mask_req got %b exp 0", bus.irq_req); end
    bus.mask = 8'hFF;
    for (int c = 0; c < 2 && !seen; c++) begin
      tick();
      if (bus.irq_req === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || bus.irq_idx !== 3'd7) begin errors++; $display("FAIL mask_unmask got %b/%0d exp 1/7", seen, bus.irq_idx); end
  endtask

  task automatic test_drop_count();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      bus.irq_in = 8'h08; tick(); bus.irq_in = 8'h00; tick();
    end
    checks++; if (bus.drop_cnt !== 8'd2) begin errors++; $display("FAIL drop_three got %0d exp 2", bus.drop_cnt); end
    for (int p = 0; p < 252; p++) begin
      bus.irq_in = 8'h08; tick(); bus.irq_in = 8'h00; tick();
    end
    checks++; if (bus.drop_cnt !== 8'd254) begin errors++; $display("FAIL drop_254 got %0d exp 254", bus.drop_cnt); end
    for (int p = 0; p < 48; p++) begin
      bus.irq_in = 8'h08; tick(); bus.irq_in = 8'h00; tick();
    end
    checks++; if (bus.drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_sat got %0d exp 255", bus.drop_cnt); end
  endtask

  task automatic test_collision_reset();
    do_reset();
    bus.irq_in = 8'h20; tick(); bus.irq_in = 8'h00; tick();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_idx !== 3'd5) begin errors++; $display("FAIL coll_req got %b/%0d exp 1/5", bus.irq_req, bus.irq_idx); end
    bus.ack = 1'b1; bus.irq_in = 8'h20; tick(); bus.ack = 1'b0; bus.irq_in = 8'h00;
    checks++; if (bus.pend !== 8'h20 || bus.irq_req !== 1'b0) begin errors++; $display("FAIL coll_pend got %h/%b exp 20/0", bus.pend, bus.irq_req); end
    checks++; if (bus.drop_cnt !== 8'd0) begin errors++; $display("FAIL coll_drop got %0d exp 0", bus.drop_cnt); end
    tick(); tick();
    checks++; if (bus.irq_req !== 1'b1 || bus.irq_idx !== 3'd5) begin errors++; $display("FAIL coll_rereq got %b/%0d exp 1/5", bus.irq_req, bus.irq_idx); end
    rst = 1'b1; bus.ack = 1'b1; bus.irq_in = 8'h10; tick();
    checks++; if (bus.pend !== 8'h00 || bus.irq_req !== 1'b0 || bus.irq_idx !== 3'd0 || bus.drop_cnt !== 8'd0)
      begin errors++; $display("FAIL rst_in_req got %h/%b/%0d/%0d exp 00/0/0/0", bus.pend, bus.irq_req, bus.irq_idx, bus.drop_cnt); end
    rst = 1'b0; bus.ack = 1'b0; tick();
    checks++; if (bus.pend !== 8'h10) begin errors++; $display("FAIL held_across_reset got %h exp 10", bus.pend); end
    bus.irq_in = 8'h00;
  endtask

  task automatic test_random();
    logic [7:0] last_in;
    logic       last_rst;
    do_reset();
    last_in = 8'h00; last_rst = 1'b1;
    for (int c = 0; c < 600; c++) begin
      checks++; if (bus.pend !== (m_pend & bus.mask)) begin errors++; $display("FAIL rand_pend cyc %0d got %h exp %h", c, bus.pend, m_pend & bus.mask); end
      checks++; if (bus.irq_req !== m_req) begin errors++; $display("FAIL rand_req cyc %0d got %b exp %b", c, bus.irq_req, m_req); end
      checks++; if (bus.irq_idx !== m_idx) begin errors++; $display("FAIL rand_idx cyc %0d got %0d exp %0d", c, bus.irq_idx, m_idx); end
      checks++; if (bus.drop_cnt !== m_drop[7:0]) begin errors++; $display("FAIL rand_drop cyc %0d got %0d exp %0d", c, bus.drop_cnt, m_drop); end
      checks++; if (lvl.drop_cnt !== 8'd0) begin errors++; $display("FAIL lvl_drop cyc %0d got %0d exp 0", c, lvl.drop_cnt); end
      if (!last_rst) begin
        checks++;
        if ((lvl.pend & last_in & bus.mask) !== (last_in & bus.mask)) begin
          errors++; $display("FAIL lvl_capture cyc %0d got %h exp bits %h", c, lvl.pend, last_in & bus.mask);
        end
      end
      rst         = ($urandom_range(0, 99) == 0);
      bus.irq_in  = 8'($urandom & $urandom & $urandom);
      bus.mask    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      bus.ack     = ($urandom_range(0, 1) == 1);
      last_in     = bus.irq_in;
      last_rst    = rst;
      tick();
    end
    rst = 1'b0; bus.ack = 1'b0; bus.irq_in = 8'h00;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; bus.irq_in = 8'h00; bus.mask = 8'hFF; bus.ack = 1'b0;
    tick();
    test_reset();
    test_single();
    test_simultaneous();
    test_mask();
    test_drop_count();
    test_collision_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_request_latch.md
IRQ_REQUEST_LATCH -- requirements
Module: irq_request_latch

Interface
REQ-001 Parameter: WIDTH, 8, number of request lines; the only supported value is 8.
REQ-002 Parameter: EDGE, 1, request capture mode (1 = rising-edge capture; 0 = level capture).
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst  input  1  synchronous, active-high reset.
REQ-005 Port: irq_in  input  8  raw request lines, already synchronous to clk.
REQ-006 Port: mask  input  8  per-line enable (1 = line may be serviced).
REQ-007 Port: pend  output  8  pend_reg & mask; drives the downstream 8-bit priority encoder input.
REQ-008 Port: idx_in  input  3  combinational index returned by that priority encoder for the current pend value.
REQ-009 Port: ack  input  1  consumer acknowledge of the presented request.
REQ-010 Port: irq_req  output  1  registered request-valid flag.
REQ-011 Port: irq_idx  output  3  registered index of the request being presented.
REQ-012 Port: drop_cnt  output  8  registered count of lost requests, saturating.

Function
REQ-013 The block SHALL keep a registered prev copy of irq_in and a pend_reg[7:0] register.
REQ-014 When EDGE=1, a 1 on irq_in[i] with prev[i]=0 SHALL set pend_reg[i] at that clock edge.
REQ-015 When EDGE=0, a 1 on irq_in[i] SHALL set pend_reg[i] at each clock edge.
REQ-016 Masking SHALL affect only the pend output and servicing; masked lines SHALL still capture into pend_reg.
REQ-017 When EDGE=1, a rising edge on a line whose pend_reg bit is already 1 SHALL increment drop_cnt by 1, saturating at 255 with no wrap.
REQ-018 When EDGE=0, drop_cnt SHALL stay 0.
REQ-019 The state machine SHALL have three states: IDLE, REQ and GAP.
REQ-020 IDLE with pend != 0 at a clock edge: irq_idx <= idx_in, irq_req <= 1, next state REQ.
REQ-021 IDLE with pend == 0: stay in IDLE; idx_in SHALL be ignored, because the encoder outputs 0 for an all-zero input.
REQ-022 In REQ, irq_idx and irq_req SHALL hold stable until ack is sampled at 1.
REQ-023 Mask or irq_in changes while in REQ SHALL NOT retract or alter the presented request.
REQ-024 REQ with ack=1 at a clock edge: clear pend_reg[irq_idx], irq_req <= 0, next state GAP.
REQ-025 GAP SHALL last exactly one cycle, then go to IDLE unconditionally; this lets the encoder settle on the updated pend.
REQ-026 A capture event on line irq_idx in the same cycle as its ack clear SHALL win; the bit stays 1 and no drop is counted.
REQ-027 ack sampled in IDLE or GAP SHALL be ignored.
REQ-028 Latency, EDGE=1: irq_in rises in cycle k -> pend visible in k+1 -> irq_req=1 in k+2.
REQ-029 Latency after ack: ack in cycle a -> irq_req=0 and the bit cleared in a+1 (GAP) -> the next request can assert no earlier than a+3.

Reset
REQ-030 While rst=1 at a clock edge, the block SHALL force pend_reg=0, prev=0, irq_req=0, irq_idx=0, drop_cnt=0 and state IDLE.
REQ-031 Reset SHALL override all other inputs, including ack.
REQ-032 Reset mid-operation SHALL discard every pending and presented request with no ack needed.
REQ-033 Because prev resets to 0, a line held high across reset release SHALL be captured as an edge in the first post-reset cycle.

Verification
REQ-034 The bench SHALL model the encoder as highest-set-bit index, with output 0 for an all-zero input.
REQ-035 Scenario, single line: irq_in pulses bit 2 for one cycle with mask=FF -> pend=00000100, then irq_req=1 with irq_idx=2; after ack -> pend=00000000, irq_req=0.
REQ-036 Scenario, simultaneous lines: bits 7 and 1 pulse together -> irq_idx=7 first; ack -> GAP -> irq_idx=1; ack -> pend=0.
REQ-037 Scenario, mask: mask=7F with bit 7 pulsed -> pend=0 and irq_req stays 0; then mask=FF -> irq_idx=7 appears within 2 cycles.
REQ-038 Scenario, drop count: bit 3 pulsed three times before any ack -> drop_cnt=2; 300 such drops -> drop_cnt=255, no wrap.
REQ-039 Scenario, collision and reset: a bit 5 edge in the same cycle as its ack -> pend[5] stays 1; rst asserted in REQ -> next cycle all outputs 0; bit 4 held high through reset release -> pend[4]=1 one cycle later.
